// File: rtl/unified_memory_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Arbitrates one access per cycle and steers the returned read data back to its owner.
module unified_memory_arbiter #(
    parameter int data_bits           = 32,
    parameter int memory_size         = 1024,
    parameter int memory_address_bits = $clog2(memory_size),
    parameter int CNT_BITS            = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           if_req,
    input  logic [memory_address_bits-1:0] if_addr,
    output logic                           if_gnt,
    output logic                           if_rvalid,
    output logic [data_bits-1:0]           if_rdata,
    output logic                           if_stall,
    input  logic                           mem_req,
    input  logic                           mem_we,
    input  logic [memory_address_bits-1:0] mem_addr,
    input  logic [data_bits-1:0]           mem_wdata,
    output logic                           mem_gnt,
    output logic                           mem_rvalid,
    output logic [data_bits-1:0]           mem_rdata,
    output logic                           mem_stall,
    output logic                           ram_en,
    output logic                           ram_we,
    output logic [memory_address_bits-1:0] ram_addr,
    output logic [data_bits-1:0]           ram_wdata,
    input  logic [data_bits-1:0]           ram_rdata,
    output logic [CNT_BITS-1:0]            conflict_cnt
);

    typedef enum logic [1:0] {IDLE, F_RD, D_RD} state_t;
    typedef enum logic {W_FETCH, W_DATA} winner_t;

    state_t               state_q, state_d;
    winner_t              last_q, last_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 both;
    logic                 fetch_win;
    logic                 data_win;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        both      = if_req & mem_req;
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (reset) begin
            if (both) begin
                fetch_win = (last_q == W_DATA);
                data_win  = (last_q == W_FETCH);
            end else begin
                fetch_win = if_req;
                data_win  = mem_req;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (data_win) begin
            state_d = mem_we ? IDLE : D_RD;
            last_d  = W_DATA;
        end else if (fetch_win) begin
            state_d = F_RD;
            last_d  = W_FETCH;
        end
        if (both && (cnt_q != {CNT_BITS{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= W_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign if_gnt       = fetch_win;
    assign mem_gnt      = data_win;
    assign if_stall     = if_req & ~fetch_win;
    assign mem_stall    = mem_req & ~data_win;

    assign ram_en       = fetch_win | data_win;
    assign ram_we       = data_win & mem_we;
    assign ram_addr     = data_win ? mem_addr : if_addr;
    assign ram_wdata    = data_win ? mem_wdata : '0;

    assign if_rvalid    = reset & (state_q == F_RD);
    assign mem_rvalid   = reset & (state_q == D_RD);
    assign if_rdata     = if_rvalid ? ram_rdata : '0;
    assign mem_rdata    = mem_rvalid ? ram_rdata : '0;
    assign conflict_cnt = cnt_q;

endmodule
